write_port_arbiter: RTL

WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

---
 rtl/write_port_arbiter_pkg.sv | 66 ++++++
 rtl/wr_dest_decode.sv | 23 ++
 rtl/write_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/write_port_arbiter_pkg.sv
// Shared types and constants for the register write-port arbiter:
// source selects, destination codes, FSM states and round-robin helpers.
package write_port_arbiter_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned DEST_W  = 5;
    localparam int unsigned WREN_W  = 20;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    localparam logic [SEL_W-1:0] SRC_NONE  = 2'd0;
    localparam logic [SEL_W-1:0] SRC_MUX3D = 2'd1;
    localparam logic [SEL_W-1:0] SRC_RG2   = 2'd2;
    localparam logic [SEL_W-1:0] SRC_TR    = 2'd3;

    localparam logic [DEST_W-1:0] DEST_R1   = 5'd1;
    localparam logic [DEST_W-1:0] DEST_R2   = 5'd2;
    localparam logic [DEST_W-1:0] DEST_R3   = 5'd3;
    localparam logic [DEST_W-1:0] DEST_R4   = 5'd4;
    localparam logic [DEST_W-1:0] DEST_R5   = 5'd5;
    localparam logic [DEST_W-1:0] DEST_R6   = 5'd6;
    localparam logic [DEST_W-1:0] DEST_R7   = 5'd7;
    localparam logic [DEST_W-1:0] DEST_R8   = 5'd8;
    localparam logic [DEST_W-1:0] DEST_R9   = 5'd9;
    localparam logic [DEST_W-1:0] DEST_R10  = 5'd10;
    localparam logic [DEST_W-1:0] DEST_R11  = 5'd11;
    localparam logic [DEST_W-1:0] DEST_R12  = 5'd12;
    localparam logic [DEST_W-1:0] DEST_R13  = 5'd13;
    localparam logic [DEST_W-1:0] DEST_R14  = 5'd14;
    localparam logic [DEST_W-1:0] DEST_PC   = 5'd15;
    localparam logic [DEST_W-1:0] DEST_TOTR = 5'd16;
    localparam logic [DEST_W-1:0] DEST_MDDR = 5'd17;
    localparam logic [DEST_W-1:0] DEST_TR   = 5'd18;
    localparam logic [DEST_W-1:0] DEST_AR   = 5'd21;
    localparam logic [DEST_W-1:0] DEST_IR   = 5'd22;
    localparam logic [DEST_W-1:0] DEST_ALL  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Index that follows i in the circular order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // First asserted request starting at the priority pointer.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        idx     = ptr;
        found   = 1'b0;
        rr_pick = ptr;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
            idx = rr_next(idx);
        end
    endfunction

endpackage

// File: rtl/wr_dest_decode.sv
// Destination code to one-hot register write-enable decode; unlisted codes
// produce no enables and raise the invalid flag.
module wr_dest_decode
    import write_port_arbiter_pkg::*;
(
    input  logic [DEST_W-1:0] dest,
    output logic [WREN_W-1:0] wr_en_c,
    output logic              invalid_c
);

    always_comb begin
        wr_en_c   = '0;
        invalid_c = 1'b0;
        case (dest) inside
            [DEST_R1:DEST_TR]: wr_en_c = WREN_W'(1) << (dest - 5'd1);
            DEST_AR:           wr_en_c[18] = 1'b1;
            DEST_IR:           wr_en_c[19] = 1'b1;
            DEST_ALL:          wr_en_c = '1;
            default:           invalid_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter for three requesters sharing the register write bus;
// issues a registered, decoded write strobe held for WRITE_CYCLES cycles.
module write_port_arbiter
    import write_port_arbiter_pkg::*;
#(
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DEST_W-1:0]  MUX3D_dest,
    input  logic [DEST_W-1:0]  RG2_dest,
    input  logic [DEST_W-1:0]  TR_dest,
    input  logic               bus_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   MUX3S,
    output logic [WREN_W-1:0]  WRDec_out,
    output logic               busy,
    output logic               err_dest
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WRITE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]    mux3s_q, mux3s_d;
    logic [WREN_W-1:0]   wrdec_q, wrdec_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [1:0]          pick_c;
    logic [DEST_W-1:0]   pick_dest_c;
    logic [WREN_W-1:0]   dec_en_c;
    logic                dec_invalid_c;

    assign pick_c = rr_pick(req, ptr_q);

    always_comb begin
        case (pick_c)
            2'd0:    pick_dest_c = MUX3D_dest;
            2'd1:    pick_dest_c = RG2_dest;
            default: pick_dest_c = TR_dest;
        endcase
    end

    wr_dest_decode u_decode (
        .dest      (dest_q),
        .wr_en_c   (dec_en_c),
        .invalid_c (dec_invalid_c)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        mux3s_d = mux3s_q;
        grant_d = '0;
        wrdec_d = '0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mux3s_d = SRC_NONE;
                if (req != '0 && !bus_busy) begin
                    win_d   = pick_c;
                    dest_d  = pick_dest_c;
                    mux3s_d = SEL_W'(pick_c + 2'd1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus_busy) begin
                    state_d = ST_WRITE;
                    cnt_d   = CNT_LOAD;
                    wrdec_d = dec_en_c;
                    err_d   = dec_invalid_c;
                    if (CNT_LOAD == '0) grant_d = 3'b001 << win_q;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ptr_d   = rr_next(win_q);
                    mux3s_d = SRC_NONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    wrdec_d = dec_en_c;
                    if (cnt_q == CNT_W'(1)) grant_d = 3'b001 << win_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mux3s_d = SRC_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            dest_q  <= '0;
            grant_q <= '0;
            mux3s_q <= SRC_NONE;
            wrdec_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            grant_q <= grant_d;
            mux3s_q <= mux3s_d;
            wrdec_q <= wrdec_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign grant     = grant_q;
    assign MUX3S     = mux3s_q;
    assign WRDec_out = wrdec_q;
    assign busy      = busy_q;
    assign err_dest  = err_q;

endmodule
